// File: rtl/ddr2_bridge_pkg.sv
// ddr2_bridge_pkg: state encoding and MIG UI command codes
// shared by the DDR2 line bridge.
package ddr2_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_WAIT,
    RESP,
    HOLD
  } state_e;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/ddr2_mig_bridge_if.sv
// ddr2_mig_bridge_if: MIG user-interface signal bundle
// (command, write-data and read-return channels plus calibration).
interface ddr2_mig_bridge_if #(
  parameter int ADDR_W = 27,
  parameter int LINE_W = 128
);

  logic              init_calib_complete;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [LINE_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [LINE_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    input  init_calib_complete,
    input  app_rdy,
    input  app_wdf_rdy,
    input  app_rd_data,
    input  app_rd_data_valid,
    output app_addr,
    output app_cmd,
    output app_en,
    output app_wdf_data,
    output app_wdf_wren,
    output app_wdf_end
  );

  modport slave (
    output init_calib_complete,
    output app_rdy,
    output app_wdf_rdy,
    output app_rd_data,
    output app_rd_data_valid,
    input  app_addr,
    input  app_cmd,
    input  app_en,
    input  app_wdf_data,
    input  app_wdf_wren,
    input  app_wdf_end
  );

endinterface

// File: rtl/ddr2_mig_bridge.sv
// ddr2_mig_bridge: one-line-at-a-time requester to MIG UI bridge.
// Writes are posted; reads return a line plus a one-cycle pulse.
module ddr2_mig_bridge
  import ddr2_bridge_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] ddr2_addr,
  input  logic              ddr2_enable,
  input  logic              ddr2_read,
  input  logic [LINE_W-1:0] to_ddr2_data,
  output logic [LINE_W-1:0] ddr2_data,
  output logic              ddr2_available,
  ddr2_mig_bridge_if.master mig
);

  state_e            state_q;
  logic              app_en_q;
  logic              wren_q;
  logic              avail_q;
  logic [2:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;

  logic              accept;
  logic              cmd_done;
  logic              wdf_done;
  logic [ADDR_W-1:0] line_addr;
  logic              unused_lo;

  assign accept    = mig.init_calib_complete && ddr2_enable;
  // byte address -> first 16-bit word of the 16-byte line
  assign line_addr = {1'b0, ddr2_addr[ADDR_W-1:4], 3'b000};
  assign unused_lo = ^ddr2_addr[3:0];
  assign cmd_done  = !app_en_q || mig.app_rdy;
  assign wdf_done  = !wren_q || mig.app_wdf_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      app_en_q <= 1'b0;
      wren_q   <= 1'b0;
      avail_q  <= 1'b0;
      cmd_q    <= CMD_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q   <= line_addr;
            app_en_q <= 1'b1;
            if (ddr2_read) begin
              cmd_q   <= CMD_READ;
              state_q <= RD_CMD;
            end else begin
              cmd_q   <= CMD_WRITE;
              wdata_q <= to_ddr2_data;
              wren_q  <= 1'b1;
              state_q <= WR;
            end
          end
        end
        // command and data channels retire independently
        WR: begin
          if (mig.app_rdy)     app_en_q <= 1'b0;
          if (mig.app_wdf_rdy) wren_q   <= 1'b0;
          if (cmd_done && wdf_done) state_q <= IDLE;
        end
        RD_CMD: begin
          if (mig.app_rdy) begin
            app_en_q <= 1'b0;
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mig.app_rd_data_valid) begin
            rdata_q <= mig.app_rd_data;
            avail_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          avail_q <= 1'b0;
          state_q <= HOLD;
        end
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mig.app_en       = app_en_q;
  assign mig.app_cmd      = cmd_q;
  assign mig.app_addr     = addr_q;
  assign mig.app_wdf_data = wdata_q;
  assign mig.app_wdf_wren = wren_q;
  assign mig.app_wdf_end  = wren_q;
  assign ddr2_data        = rdata_q;
  assign ddr2_available   = avail_q;

endmodule

// File: tb/tb_ddr2_mig_bridge.sv
// tb_ddr2_mig_bridge: vector table, directed corners and random
// traffic against a MIG memory model and a line-level reference.
module tb_ddr2_mig_bridge;

  localparam int AW = 27;
  localparam int LW = 128;
  localparam logic [LW-1:0] XDAT =
    128'h0123_4567_89AB_CDEF_DEAD_BEEF_F00D_FACE;
  localparam logic [LW-1:0] D1 =
    128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [LW-1:0] D2 =
    128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
  localparam logic [LW-1:0] D3 =
    128'h1111_0000_2222_0000_3333_0000_4444_0001;
  localparam logic [LW-1:0] D6 =
    128'hCAFE_F00D_1234_5678_9ABC_DEF0_0BAD_C0DE;
  localparam logic [LW-1:0] D7 =
    128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [LW-1:0] A5 = {16{8'hA5}};

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [AW-1:0] ddr2_addr = '0;
  logic          ddr2_enable = 1'b0;
  logic          ddr2_read = 1'b0;
  logic [LW-1:0] to_ddr2_data = '0;
  logic [LW-1:0] ddr2_data;
  logic          ddr2_available;

  ddr2_mig_bridge_if #(.ADDR_W(AW), .LINE_W(LW)) m ();

  ddr2_mig_bridge #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ddr2_addr     (ddr2_addr),
    .ddr2_enable   (ddr2_enable),
    .ddr2_read     (ddr2_read),
    .to_ddr2_data  (to_ddr2_data),
    .ddr2_data     (ddr2_data),
    .ddr2_available(ddr2_available),
    .mig           (m)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // MIG model: programmable handshake delays and read latency
  int  rdy_dly = 0;
  int  wdf_dly = 0;
  int  rd_lat = 1;
  bit  spur = 1'b0;
  bit  seeded = 1'b0;
  int  en_cnt = 0;
  int  wdf_cnt = 0;
  int  rd_cnt = 0;
  bit  rd_pend = 1'b0;
  bit  have_wc = 1'b0;
  bit  have_wd = 1'b0;
  int  n_wcmd = 0;
  int  n_rcmd = 0;
  int  n_wren = 0;
  int  n_pulse = 0;
  int  n_en_cyc = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wc_addr = '0;
  logic [AW-1:0] last_cmd_addr = '0;
  logic [LW-1:0] wbuf = '0;
  logic [LW-1:0] mem [logic [AW-1:0]];

  function automatic logic [LW-1:0] fill(input logic [AW-1:0] wa);
    logic [31:0] w;
    w = {5'b0, wa} ^ 32'h5A5A_0000;
    return {4{w}};
  endfunction

  function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return fill(wa);
  endfunction

  always @(negedge clk) begin
    if (!seeded) begin
      mem[27'h918] = XDAT;
      m.app_rd_data = '0;
      seeded = 1'b1;
    end
    m.app_rd_data_valid = 1'b0;
    if (spur) begin
      m.app_rd_data_valid = 1'b1;
      m.app_rd_data = {$urandom, $urandom, $urandom, $urandom};
    end
    if (rd_pend) begin
      rd_cnt--;
      if (rd_cnt <= 0) begin
        m.app_rd_data_valid = 1'b1;
        m.app_rd_data = mem_rd(rd_addr);
        rd_pend = 1'b0;
      end
    end
    if (ddr2_available) n_pulse++;
    if (m.app_en) n_en_cyc++;
    m.app_rdy = 1'b0;
    if (m.app_en) begin
      if (en_cnt >= rdy_dly) begin
        m.app_rdy = 1'b1;
        last_cmd_addr = m.app_addr;
        if (m.app_cmd == 3'b001) begin
          n_rcmd++;
          rd_pend = 1'b1;
          rd_cnt = rd_lat;
          rd_addr = m.app_addr;
        end else begin
          n_wcmd++;
          have_wc = 1'b1;
          wc_addr = m.app_addr;
        end
      end
      en_cnt++;
    end else begin
      en_cnt = 0;
    end
    m.app_wdf_rdy = 1'b0;
    if (m.app_wdf_wren) begin
      if (wdf_cnt >= wdf_dly) begin
        m.app_wdf_rdy = 1'b1;
        n_wren++;
        have_wd = 1'b1;
        wbuf = m.app_wdf_data;
        chk("wdf_end", LW'(m.app_wdf_end), LW'(1));
      end
      wdf_cnt++;
    end else begin
      wdf_cnt = 0;
    end
    if (have_wc && have_wd) begin
      mem[wc_addr] = wbuf;
      have_wc = 1'b0;
      have_wd = 1'b0;
    end
  end

  task automatic chk_reset(input string t);
    chk({t, ":avail"}, LW'(ddr2_available), LW'(0));
    chk({t, ":app_en"}, LW'(m.app_en), LW'(0));
    chk({t, ":wren"}, LW'(m.app_wdf_wren), LW'(0));
    chk({t, ":wend"}, LW'(m.app_wdf_end), LW'(0));
    chk({t, ":cmd"}, LW'(m.app_cmd), LW'(3'b001));
    chk({t, ":addr"}, LW'(m.app_addr), LW'(0));
    chk({t, ":wdata"}, m.app_wdf_data, LW'(0));
    chk({t, ":rdata"}, ddr2_data, LW'(0));
  endtask

  task automatic wait_pulse(output bit ok, output logic [LW-1:0] d);
    ok = 1'b0;
    d = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ddr2_available) begin
        ok = 1'b1;
        d = ddr2_data;
        break;
      end
    end
  endtask

  task automatic run_tx(input string nm, input bit rd,
                        input logic [AW-1:0] a, input logic [LW-1:0] wd,
                        input int rdly, input int wdly, input int lat,
                        input logic [AW-1:0] exp_app,
                        input logic [LW-1:0] exp_rd);
    int s_w, s_r, s_e, s_p;
    bit ok;
    logic [LW-1:0] got;
    rdy_dly = rdly;
    wdf_dly = wdly;
    rd_lat = lat;
    s_w = n_wcmd;
    s_r = n_rcmd;
    s_e = n_wren;
    s_p = n_pulse;
    @(negedge clk);
    ddr2_addr = a;
    ddr2_read = rd;
    ddr2_enable = 1'b1;
    to_ddr2_data = wd;
    if (rd) begin
      wait_pulse(ok, got);
      chk({nm, ":done"}, LW'(ok), LW'(1));
      chk({nm, ":rdata"}, got, exp_rd);
      @(negedge clk);
      @(negedge clk);
      ddr2_enable = 1'b0;
    end else begin
      @(negedge clk);
      ddr2_enable = 1'b0;
      to_ddr2_data = {$urandom, $urandom, $urandom, $urandom};
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        if (n_wcmd != s_w && n_wren != s_e) ok = 1'b1;
        else @(negedge clk);
      end
      chk({nm, ":done"}, LW'(ok), LW'(1));
      repeat (3) @(negedge clk);
      chk({nm, ":mem"}, mem_rd(exp_app), wd);
    end
    repeat (2) @(negedge clk);
    chk({nm, ":app_addr"}, LW'(last_cmd_addr), LW'(exp_app));
    chk({nm, ":wcmds"}, LW'(n_wcmd - s_w), LW'(rd ? 0 : 1));
    chk({nm, ":rcmds"}, LW'(n_rcmd - s_r), LW'(rd ? 1 : 0));
    chk({nm, ":wrens"}, LW'(n_wren - s_e), LW'(rd ? 0 : 1));
    chk({nm, ":pulses"}, LW'(n_pulse - s_p), LW'(rd ? 1 : 0));
    chk({nm, ":en_idle"}, LW'(m.app_en), LW'(0));
    chk({nm, ":wren_idle"}, LW'(m.app_wdf_wren), LW'(0));
  endtask

  typedef struct {
    bit            rd;
    logic [AW-1:0] a;
    logic [LW-1:0] wd;
    int            rdly;
    int            wdly;
    int            lat;
    logic [AW-1:0] exp_app;
    logic [LW-1:0] exp_rd;
  } vec_t;

  vec_t vt [9];
  logic [LW-1:0] ref_mem [int];
  int s_w, s_r, s_p, s_e;
  bit ok;
  logic [LW-1:0] got;

  initial begin : main
    vt[0] = '{1'b1, 27'h0001230, '0, 3, 0, 5, 27'h0000918, XDAT};
    vt[1] = '{1'b0, 27'h0000100, D1, 2, 0, 1, 27'h0000080, '0};
    vt[2] = '{1'b0, 27'h0000110, D2, 0, 2, 1, 27'h0000088, '0};
    vt[3] = '{1'b0, 27'h0000120, D3, 1, 1, 1, 27'h0000090, '0};
    vt[4] = '{1'b1, 27'h000010F, '0, 0, 0, 1, 27'h0000080, D1};
    vt[5] = '{1'b1, 27'h7FFFFFF, '0, 1, 0, 2, 27'h3FFFFF8,
              fill(27'h3FFFFF8)};
    vt[6] = '{1'b0, 27'h7FFFFF5, D6, 0, 0, 1, 27'h3FFFFF8, '0};
    vt[7] = '{1'b1, 27'h7FFFFF0, '0, 2, 0, 4, 27'h3FFFFF8, D6};
    vt[8] = '{1'b1, 27'h000011C, '0, 1, 0, 3, 27'h0000088, D2};

    m.init_calib_complete = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_tx($sformatf("vec%0d", i), vt[i].rd, vt[i].a, vt[i].wd,
             vt[i].rdly, vt[i].wdly, vt[i].lat, vt[i].exp_app,
             vt[i].exp_rd);

    // posted write with the read already held during WR
    rdy_dly = 1;
    wdf_dly = 2;
    rd_lat = 2;
    s_w = n_wcmd;
    s_r = n_rcmd;
    s_p = n_pulse;
    @(negedge clk);
    ddr2_addr = 27'h40;
    ddr2_read = 1'b0;
    ddr2_enable = 1'b1;
    to_ddr2_data = A5;
    @(negedge clk);
    ddr2_read = 1'b1;
    to_ddr2_data = '0;
    wait_pulse(ok, got);
    chk("wr_rd:done", LW'(ok), LW'(1));
    chk("wr_rd:rdata", got, A5);
    repeat (2) @(negedge clk);
    ddr2_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("wr_rd:wcmds", LW'(n_wcmd - s_w), LW'(1));
    chk("wr_rd:rcmds", LW'(n_rcmd - s_r), LW'(1));
    chk("wr_rd:pulses", LW'(n_pulse - s_p), LW'(1));
    chk("wr_rd:addr", LW'(last_cmd_addr), LW'(27'h20));

    // calibration gate, then calibration dropping mid-read
    rdy_dly = 2;
    rd_lat = 3;
    s_e = n_en_cyc;
    s_r = n_rcmd;
    s_p = n_pulse;
    @(negedge clk);
    m.init_calib_complete = 1'b0;
    ddr2_addr = 27'h1230;
    ddr2_read = 1'b1;
    ddr2_enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("calib:no_en", LW'(n_en_cyc - s_e), LW'(0));
    m.init_calib_complete = 1'b1;
    @(negedge clk);
    chk("calib:accept", LW'(m.app_en), LW'(1));
    m.init_calib_complete = 1'b0;
    wait_pulse(ok, got);
    chk("calib:done", LW'(ok), LW'(1));
    chk("calib:rdata", got, XDAT);
    repeat (2) @(negedge clk);
    ddr2_enable = 1'b0;
    m.init_calib_complete = 1'b1;
    repeat (2) @(negedge clk);
    chk("calib:rcmds", LW'(n_rcmd - s_r), LW'(1));
    chk("calib:pulses", LW'(n_pulse - s_p), LW'(1));

    // stray read-valid while writing and idle
    spur = 1'b1;
    run_tx("spur_wr", 1'b0, 27'h130, D7, 1, 0, 1, 27'h98, '0);
    repeat (4) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur:hold", ddr2_data, XDAT);

    // reset while waiting on read data
    rdy_dly = 0;
    rd_lat = 12;
    s_r = n_rcmd;
    s_p = n_pulse;
    @(negedge clk);
    ddr2_addr = 27'h40;
    ddr2_read = 1'b1;
    ddr2_enable = 1'b1;
    for (int i = 0; i < 50 && n_rcmd == s_r; i++) @(negedge clk);
    chk("rst:cmd_seen", LW'(n_rcmd - s_r), LW'(1));
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    ddr2_enable = 1'b0;
    @(negedge clk);
    chk_reset("rst_mid");
    s_p = n_pulse;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst:no_pulse", LW'(n_pulse - s_p), LW'(0));
    chk("rst:rdata", ddr2_data, LW'(0));
    chk("rst:app_en", LW'(m.app_en), LW'(0));

    // random traffic over four lines against a line-indexed model
    for (int t = 0; t < 40; t++) begin
      int line;
      bit rd;
      logic [AW-1:0] a;
      logic [LW-1:0] wd;
      logic [LW-1:0] er;
      line = 32 + int'($urandom_range(0, 3));
      a = AW'(line * 16 + int'($urandom_range(0, 15)));
      rd = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom, $urandom, $urandom};
      er = ref_mem.exists(line) ? ref_mem[line] : fill(AW'(line * 8));
      run_tx($sformatf("rnd%0d", t), rd, a, wd,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(1, 4)), AW'(line * 8), er);
      if (!rd) ref_mem[line] = wd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
